pll_mdrp_ctrl: RTL and testbench

PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

---
 rtl/pll_mdrp_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pll_mdrp_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pll_mdrp_ctrl.sv
// Host-side controller for a PLL configuration port: seeks the auto-incrementing
// address pointer to the target register, issues one write or read, and optionally resets the PLL and waits for lock.
module pll_mdrp_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_commit,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       md_clk,
    output logic [1:0] md_opc,
    output logic       md_ainc,
    output logic [7:0] md_wdi,
    input  logic [7:0] md_rdo,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic [6:0] cur_ptr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEEK  = 3'd1,
        OP    = 3'd2,
        RDCAP = 3'd3,
        PRST  = 3'd4,
        LOCKW = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [1:0] OPC_NOP   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;

    state_t      state_r;
    logic        md_clk_r;
    logic [1:0]  md_opc_r;
    logic        md_ainc_r;
    logic [7:0]  md_wdi_r;
    logic        pll_reset_r;
    logic [6:0]  ptr_r;
    logic [6:0]  seek_cnt_r;
    logic [31:0] cnt_r;
    logic        wr_r;
    logic        commit_r;
    logic [7:0]  wdata_r;
    logic        err_r;
    logic        done_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [7:0]  rsp_rdata_r;
    logic        ready_r;
    logic [6:0]  dist_s;

    function automatic logic [1:0] op_code(input logic wr);
        op_code = wr ? OPC_WRITE : OPC_READ;
    endfunction

    function automatic logic [7:0] op_data(input logic wr, input logic [7:0] data);
        op_data = wr ? data : 8'h00;
    endfunction

    // Forward distance from the tracked pointer to the target; wraps mod 128.
    assign dist_s = req_addr - ptr_r;

    // Transaction sequencer; every port-facing output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            md_clk_r    <= 1'b0;
            md_opc_r    <= OPC_NOP;
            md_ainc_r   <= 1'b0;
            md_wdi_r    <= 8'h00;
            pll_reset_r <= 1'b0;
            ptr_r       <= 7'd0;
            seek_cnt_r  <= 7'd0;
            cnt_r       <= 32'd0;
            wr_r        <= 1'b0;
            commit_r    <= 1'b0;
            wdata_r     <= 8'h00;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 8'h00;
            ready_r     <= 1'b1;
        end else if (state_r == IDLE) begin
            md_clk_r    <= 1'b0;
            md_opc_r    <= OPC_NOP;
            md_ainc_r   <= 1'b0;
            md_wdi_r    <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            if (req_valid && ready_r) begin
                ready_r    <= 1'b0;
                wr_r       <= req_write;
                commit_r   <= req_write && req_commit;
                wdata_r    <= req_wdata;
                err_r      <= 1'b0;
                done_r     <= 1'b0;
                seek_cnt_r <= dist_s;
                if (dist_s != 7'd0) begin
                    state_r   <= SEEK;
                    md_ainc_r <= 1'b1;
                end else begin
                    state_r  <= OP;
                    md_opc_r <= op_code(req_write);
                    md_wdi_r <= op_data(req_write, req_wdata);
                end
            end else begin
                ready_r <= 1'b1;
            end
        end else begin
            // md_clk free-runs while busy; period boundaries are where md_clk_r is high.
            md_clk_r <= ~md_clk_r;
            case (state_r)
                SEEK: begin
                    if (md_clk_r) begin
                        ptr_r <= ptr_r + 7'd1;
                        if (seek_cnt_r == 7'd1) begin
                            state_r   <= OP;
                            md_ainc_r <= 1'b0;
                            md_opc_r  <= op_code(wr_r);
                            md_wdi_r  <= op_data(wr_r, wdata_r);
                        end else begin
                            seek_cnt_r <= seek_cnt_r - 7'd1;
                        end
                    end
                end
                OP: begin
                    if (md_clk_r) begin
                        md_opc_r <= OPC_NOP;
                        md_wdi_r <= 8'h00;
                        if (!wr_r) begin
                            state_r <= RDCAP;
                        end else if (commit_r) begin
                            state_r     <= PRST;
                            pll_reset_r <= 1'b1;
                            cnt_r       <= 32'(RST_CYCLES - 1);
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                RDCAP: begin
                    if (md_clk_r) begin
                        rsp_rdata_r <= md_rdo;
                        state_r     <= DONE;
                    end
                end
                PRST: begin
                    if (cnt_r == 32'd0) begin
                        pll_reset_r <= 1'b0;
                        state_r     <= LOCKW;
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                LOCKW: begin
                    // Lock is checked before the timeout so a lock on the last cycle still succeeds.
                    if (pll_lock) begin
                        state_r <= DONE;
                    end else if (cnt_r == 32'(LOCK_TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                DONE: begin
                    if (!done_r) begin
                        done_r      <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= err_r;
                    end else begin
                        done_r      <= 1'b0;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        md_clk_r    <= 1'b0;
                        ready_r     <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    md_clk_r    <= 1'b0;
                    md_opc_r    <= OPC_NOP;
                    md_ainc_r   <= 1'b0;
                    md_wdi_r    <= 8'h00;
                    pll_reset_r <= 1'b0;
                    ready_r     <= 1'b1;
                end
            endcase
        end
    end

    // rst_n also clears the PLL-side pointer, so ptr_r starting at 0 keeps both in step.
    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign md_clk    = md_clk_r;
    assign md_opc    = md_opc_r;
    assign md_ainc   = md_ainc_r;
    assign md_wdi    = md_wdi_r;
    assign pll_reset = pll_reset_r;
    assign cur_ptr   = ptr_r;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Self-checking bench for pll_mdrp_ctrl: directed vector table, mid-seek reset,
// then random transactions scored against an arithmetic latency/pointer model.
module tb_pll_mdrp_ctrl;

    localparam int RST = 16;
    localparam int LT  = 65535;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write, req_commit;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       md_clk, md_ainc, pll_reset, pll_lock;
    logic [1:0] md_opc;
    logic [7:0] md_wdi, md_rdo;
    logic [6:0] cur_ptr;

    pll_mdrp_ctrl #(.RST_CYCLES(RST), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_commit(req_commit), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .md_clk(md_clk), .md_opc(md_opc), .md_ainc(md_ainc),
        .md_wdi(md_wdi), .md_rdo(md_rdo), .pll_reset(pll_reset),
        .pll_lock(pll_lock), .cur_ptr(cur_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         cm;
        bit         hold;
        logic [6:0] a;
        logic [7:0] wd;
        logic [7:0] rdo;
        int         d;
        int         n;
        int         lat;
        int         ptr;
        int         err;
        int         rdata;
    } vec_t;

    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr;
    int   m_rdata;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: latency/pointer/error derived directly from the protocol rules.
    function automatic vec_t model(input bit wr, input bit cm, input logic [6:0] a,
                                   input logic [7:0] wd, input logic [7:0] rdo, input int d);
        vec_t v;
        int   lockw_len;
        v.wr = wr; v.cm = cm; v.hold = 1'b0; v.a = a; v.wd = wd; v.rdo = rdo; v.d = d;
        v.n = (int'(a) - m_ptr + 128) % 128;
        lockw_len = (d + 1 < LT) ? d + 1 : LT;
        if (!wr)     v.lat = 2 * v.n + 5;
        else if (cm) v.lat = 2 * v.n + 3 + RST + lockw_len;
        else         v.lat = 2 * v.n + 3;
        v.err   = (wr && cm && d >= LT) ? 1 : 0;
        v.ptr   = int'(a);
        v.rdata = wr ? m_rdata : int'(rdo);
        return v;
    endfunction

    // Called just after a negedge with the DUT idle; returns at the negedge of the first idle cycle after completion.
    task automatic run_txn(input vec_t v, input string tag);
        int n_ainc = 0, n_w = 0, n_r = 0, n_rst = 0;
        int bad_wdi = 0, bad_clk = 0, bad_rdy = 0, lat = -1;
        int lock_at = 2 * v.n + 2 + RST + v.d;
        req_valid = 1'b1; req_write = v.wr; req_commit = v.cm;
        req_addr = v.a; req_wdata = v.wd; md_rdo = v.rdo; pll_lock = 1'b0;
        @(posedge clk);
        for (int j = 0; j < v.lat + 40; j++) begin
            @(negedge clk);
            if (!v.hold) begin
                req_valid = 1'b0;
            end else begin
                req_addr = 7'($urandom); req_wdata = 8'($urandom);
                req_write = 1'($urandom); req_commit = 1'($urandom);
            end
            pll_lock = (v.wr && v.cm && j >= lock_at);
            if (md_ainc) n_ainc++;
            if (md_opc == 2'b01) begin
                n_w++;
                if (md_wdi !== v.wd) bad_wdi++;
            end else if (md_wdi !== 8'h00) begin
                bad_wdi++;
            end
            if (md_opc == 2'b10) n_r++;
            if (md_opc == 2'b11) bad_wdi++;
            if (pll_reset) n_rst++;
            if (md_clk !== j[0]) bad_clk++;
            if (req_ready !== 1'b0) bad_rdy++;
            if (rsp_valid === 1'b1) begin
                lat = j;
                break;
            end
        end
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".rsp_err"}, int'(rsp_err), v.err);
        check({tag, ".rsp_rdata"}, int'(rsp_rdata), v.rdata);
        check({tag, ".ainc_clks"}, n_ainc, 2 * v.n);
        check({tag, ".write_clks"}, n_w, v.wr ? 2 : 0);
        check({tag, ".read_clks"}, n_r, v.wr ? 0 : 2);
        check({tag, ".pll_reset_clks"}, n_rst, (v.wr && v.cm) ? RST : 0);
        check({tag, ".wdi_errs"}, bad_wdi, 0);
        check({tag, ".md_clk_errs"}, bad_clk, 0);
        check({tag, ".busy_ready"}, bad_rdy, 0);
        @(negedge clk);
        pll_lock = 1'b0;
        if (v.hold) begin
            req_write = v.wr; req_commit = v.cm; req_addr = v.a; req_wdata = v.wd;
        end
        check({tag, ".idle_ready"}, int'(req_ready), 1);
        check({tag, ".idle_outs"}, int'({md_clk, md_opc, md_ainc, md_wdi, rsp_valid, pll_reset}), 0);
        check({tag, ".cur_ptr"}, int'(cur_ptr), v.ptr);
        m_ptr = v.ptr;
        m_rdata = v.rdata;
    endtask

    initial begin
        //            wr  cm  hold addr    wdata  rdo    d       n    lat    ptr  err rdata
        tbl[0] = '{1'b1, 1'b0, 1'b0, 7'd0,   8'hA5, 8'h00, 0,      0,   3,     0,   0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 7'd3,   8'h00, 8'h3C, 0,      3,   11,    3,   0, 8'h3C};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 7'd5,   8'h11, 8'h00, 0,      2,   7,     5,   0, 8'h3C};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 7'd3,   8'h22, 8'h00, 0,      126, 255,   3,   0, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 7'd3,   8'h00, 8'h5A, 0,      0,   5,     3,   0, 8'h5A};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 7'd3,   8'h33, 8'h00, 40,     0,   60,    3,   0, 8'h5A};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 7'd10,  8'h44, 8'h00, 0,      7,   34,    10,  0, 8'h5A};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 7'd10,  8'h00, 8'hC3, 0,      0,   5,     10,  0, 8'hC3};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 7'd10,  8'h00, 8'hC3, 0,      0,   5,     10,  0, 8'hC3};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 7'd127, 8'h66, 8'h00, 100000, 117, 65788, 127, 1, 8'hC3};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_commit = 1'b0;
        req_addr = 7'd0; req_wdata = 8'h00; md_rdo = 8'h00; pll_lock = 1'b0;
        m_ptr = 0; m_rdata = 0;
        repeat (3) @(negedge clk);
        check("reset.outs", int'({md_clk, md_opc, md_ainc, md_wdi, pll_reset, rsp_valid, rsp_err, rsp_rdata, cur_ptr}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.ready_after_release", int'(req_ready), 1);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset in the middle of a long seek (127 -> 100, 101 periods).
        req_valid = 1'b1; req_write = 1'b0; req_commit = 1'b0; req_addr = 7'd100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midseek.ptr_before", int'(cur_ptr), 2);
        check("midseek.ainc_before", int'(md_ainc), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midseek.outs_in_reset", int'({md_clk, md_opc, md_ainc, md_wdi, pll_reset, rsp_valid, rsp_err, rsp_rdata, cur_ptr}), 0);
        check("midseek.ready_in_reset", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midseek.ready_after_release", int'(req_ready), 1);
        m_ptr = 0; m_rdata = 0;
        run_txn(tbl[0], "post_reset");

        for (int i = 0; i < 30; i++) begin
            vec_t v;
            bit   wr = 1'($urandom);
            bit   cm = ($urandom_range(0, 3) == 0);
            v = model(wr, cm, 7'($urandom_range(0, 127)), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 60)));
            run_txn(v, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
